// File: rtl/fifo_burst_reader.sv
// Burst read master for the synchronous fifo: pops burst_len words, hides the
// one-cycle fifo read latency and replays the words on a valid/ready stream.
//
// state | meaning
// IDLE  | waiting for start; words_sent holds the last burst count
// RUN   | fetching from the fifo and draining the output buffer
// DONE  | one-cycle done pulse, then back to IDLE
module fifo_burst_reader #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    output logic             busy,
    output logic             done,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [LEN_W-1:0] words_sent
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] fetch_left;
    logic [LEN_W-1:0] send_left;
    logic [LEN_W-1:0] sent_cnt;
    logic [WIDTH-1:0] buf_mem [4];
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;
    logic [2:0]       occ;
    logic             inflight;
    logic             accept;
    logic             handshake;

    assign m_valid    = (occ != 3'd0);
    assign m_data     = buf_mem[rd_ptr];
    assign handshake  = m_valid && m_ready;
    assign busy       = (state == S_RUN);
    assign done       = (state == S_DONE);
    assign words_sent = sent_cnt;

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        fifo_rd_en = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (burst_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // A word already in flight still needs a buffer slot when it lands.
                fifo_rd_en = !fifo_empty && (fetch_left != '0) &&
                             ((occ + {2'b00, inflight}) < 3'd4);
                if (handshake && (send_left == LEN_W'(1)))
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_left <= '0;
            send_left  <= '0;
            sent_cnt   <= '0;
            inflight   <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
            if (accept) begin
                fetch_left <= burst_len;
                send_left  <= burst_len;
                sent_cnt   <= '0;
            end else begin
                if (fifo_rd_en)
                    fetch_left <= fetch_left - LEN_W'(1);
                if (handshake) begin
                    send_left <= send_left - LEN_W'(1);
                    sent_cnt  <= sent_cnt + LEN_W'(1);
                end
            end
        end
    end

    // Output buffer: written from fifo_dout one cycle after each pop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 4; i++)
                buf_mem[i] <= '0;
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            occ    <= 3'd0;
        end else begin
            if (inflight) begin
                buf_mem[wr_ptr] <= fifo_dout;
                wr_ptr          <= wr_ptr + 2'd1;
            end
            if (handshake)
                rd_ptr <= rd_ptr + 2'd1;
            case ({inflight, handshake})
                2'b10:   occ <= occ + 3'd1;
                2'b01:   occ <= occ - 3'd1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based fifo model feeds the DUT and a
// scoreboard of popped words checks stream order, stalls and burst counts.
module tb_fifo_burst_reader;

    logic       clk;
    logic       rstn;
    logic       start;
    logic [7:0] burst_len;
    logic       busy;
    logic       done;
    logic       fifo_rd_en;
    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] words_sent;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    int         pops_b;
    int         sent_b;
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [7:0] last_data;

    fifo_burst_reader #(.WIDTH(8), .LEN_W(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .burst_len  (burst_len),
        .busy       (busy),
        .done       (done),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .words_sent (words_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] v);
        fq.push_back(v);
        fifo_empty = 1'b0;
    endtask

    // One clock: sample just after the falling edge, model the fifo pop just
    // after the rising edge, return on the next falling edge.
    task automatic tick();
        logic       pop_s;
        logic       hs_s;
        logic [7:0] d_s;
        #1;
        pop_s = fifo_rd_en && !fifo_empty;
        hs_s  = m_valid && m_ready;
        chk("rd_en_while_empty", 32'(fifo_rd_en & fifo_empty), 0);
        chk("outstanding_le_4", 32'((pops_b - sent_b) <= 4), 1);
        if (prev_stall) begin
            chk("stall_valid", 32'(m_valid), 1);
            chk("stall_data", 32'(m_data), 32'(prev_data));
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        if (hs_s) begin
            chk("hs_has_word", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0)
                chk("hs_data", 32'(m_data), 32'(exp_q.pop_front()));
            last_data = m_data;
            sent_b++;
        end
        @(posedge clk);
        #1;
        if (pop_s) begin
            d_s       = fq.pop_front();
            fifo_dout = d_s;
            exp_q.push_back(d_s);
            pops_b++;
        end
        fifo_empty = (fq.size() == 0);
        @(negedge clk);
    endtask

    task automatic start_burst(input int len);
        pops_b    = 0;
        sent_b    = 0;
        start     = 1'b1;
        burst_len = 8'(len);
        tick();
        start     = 1'b0;
        burst_len = 8'($urandom);
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0, 2: random ready
    task automatic finish_burst(input int len, input int mode, input int max_cyc, input int push_need);
        int cyc;
        int need;
        cyc  = 0;
        need = push_need;
        while (!done && cyc < max_cyc) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (cyc % 3 == 0);
                default: m_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (need > 0 && $urandom_range(0, 1) == 1) begin
                push_word(8'($urandom));
                need--;
            end
            tick();
            cyc++;
        end
        chk("done_within_budget", 32'(done), 1);
        chk("done_busy_low", 32'(busy), 0);
        chk("words_sent", 32'(words_sent), 32'(len));
        chk("pops_eq_len", 32'(pops_b), 32'(len));
        chk("handshakes_eq_len", 32'(sent_b), 32'(len));
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        m_ready = 1'b1;
        tick();
        chk("done_one_cycle", 32'(done), 0);
        chk("idle_busy_low", 32'(busy), 0);
    endtask

    initial begin
        rstn       = 1'b0;
        start      = 1'b0;
        burst_len  = 8'd0;
        m_ready    = 1'b0;
        fifo_dout  = 8'd0;
        fifo_empty = 1'b1;
        pops_b     = 0;
        sent_b     = 0;
        prev_stall = 1'b0;
        prev_data  = 8'd0;
        last_data  = 8'd0;

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            start      = 1'($urandom);
            burst_len  = 8'($urandom);
            m_ready    = 1'($urandom);
            fifo_empty = 1'($urandom);
            fifo_dout  = 8'($urandom);
            @(negedge clk);
            #1;
            chk("reset_outputs", 32'({busy, done, fifo_rd_en, m_valid, m_data, words_sent}), 0);
        end
        start      = 1'b0;
        m_ready    = 1'b1;
        fifo_empty = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        tick();
        chk("idle_rd_en", 32'(fifo_rd_en), 0);
        chk("idle_busy", 32'(busy), 0);

        // Basic burst with latency and throughput
        push_word(8'hAA);
        push_word(8'hBB);
        push_word(8'hCC);
        m_ready = 1'b1;
        start_burst(3);
        chk("e0_busy", 32'(busy), 1);
        chk("e0_rd_en", 32'(fifo_rd_en), 1);
        chk("e0_valid", 32'(m_valid), 0);
        tick();
        chk("e1_valid", 32'(m_valid), 0);
        tick();
        chk("e2_valid", 32'(m_valid), 1);
        chk("word0", 32'(m_data), 32'h AA);
        tick();
        chk("word1", 32'(m_data), 32'h BB);
        tick();
        chk("word2", 32'(m_data), 32'h CC);
        tick();
        chk("basic_done", 32'(done), 1);
        chk("basic_busy", 32'(busy), 0);
        chk("basic_words_sent", 32'(words_sent), 3);
        chk("basic_fifo_empty", 32'(fifo_empty), 1);
        tick();
        chk("basic_done_pulse", 32'(done), 0);

        // Backpressure, with a start pulse during RUN that must be ignored
        for (int i = 0; i < 10; i++)
            push_word(8'(8'h10 + i));
        start_burst(8);
        m_ready   = 1'b0;
        start     = 1'b1;
        burst_len = 8'd3;
        tick();
        start = 1'b0;
        finish_burst(8, 1, 200, 0);
        chk("bp_last_word", 32'(last_data), 32'h17);
        chk("bp_fifo_left", 32'(fq.size()), 2);

        // Zero-length burst with a non-empty fifo
        start_burst(0);
        chk("zero_done", 32'(done), 1);
        chk("zero_busy", 32'(busy), 0);
        chk("zero_rd_en", 32'(fifo_rd_en), 0);
        chk("zero_words_sent", 32'(words_sent), 0);
        tick();
        chk("zero_done_pulse", 32'(done), 0);
        chk("zero_pops", 32'(pops_b), 0);

        // Drain the two leftovers with random backpressure
        start_burst(2);
        finish_burst(2, 2, 100, 0);
        chk("drain_last", 32'(last_data), 32'h19);

        // Empty stall
        push_word(8'hE0);
        push_word(8'hE1);
        start_burst(4);
        m_ready = 1'b1;
        repeat (5) tick();
        chk("stall_sent", 32'(sent_b), 2);
        chk("stall_rd_en", 32'(fifo_rd_en), 0);
        chk("stall_busy", 32'(busy), 1);
        chk("stall_no_done", 32'(done), 0);
        push_word(8'hE2);
        push_word(8'hE3);
        finish_burst(4, 0, 50, 0);
        chk("stall_last", 32'(last_data), 32'hE3);

        // Mid-burst reset
        for (int i = 0; i < 5; i++)
            push_word(8'(8'h50 + i));
        m_ready = 1'b1;
        start_burst(5);
        tick();
        tick();
        rstn = 1'b0;
        #1;
        chk("midrst_outputs", 32'({busy, done, fifo_rd_en, m_valid, m_data, words_sent}), 0);
        exp_q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        start_burst(2);
        finish_burst(2, 0, 50, 0);
        chk("midrst_last", 32'(last_data), 32'h53);
        chk("midrst_fifo_left", 32'(fq.size()), 1);

        // Random bursts with random data arrival and backpressure
        for (int k = 0; k < 6; k++) begin
            int len;
            int pre;
            len = $urandom_range(1, 20);
            pre = $urandom_range(0, len);
            for (int i = 0; i < pre; i++)
                push_word(8'($urandom));
            start_burst(len);
            finish_burst(len, 2, 600, len - pre);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
